// File: rtl/vreg_lane_requester_pkg.sv
// Shared definitions for the vector-register crossbar: geometry, request
// record and the lane requester state encoding.
package vreg_lane_requester_pkg;

  localparam int NUM_OF_VECTOR_REG = 8;
  localparam int VECTOR_REG_DEPTH  = 16;
  localparam int VECTOR_REG_WIDTH  = 32;

  localparam int VREG_W = $clog2(NUM_OF_VECTOR_REG);
  localparam int AW     = $clog2(VECTOR_REG_DEPTH);

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_e;

  typedef struct packed {
    logic                        vld;
    logic [VREG_W-1:0]           vec_reg_ptr;
    logic [AW-1:0]               addr;
    access_type_e                access_type;
    logic [AW-1:0]               access_length;
    logic [VECTOR_REG_WIDTH-1:0] data;
  } cntrl_req_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    FIN  = 3'd4
  } vreq_state_e;

  // Element address inside a vector register; wraps at the register depth.
  function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                              input logic [AW:0]   idx);
    return base + idx[AW-1:0];
  endfunction

endpackage

// File: rtl/vreg_lane_requester.sv
// Lane-side crossbar initiator: splits a vector command into single-element
// requests, reissues ungranted ones and hands read data back to the lane.
module vreg_lane_requester
  import vreg_lane_requester_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  input  logic                        cmd_write,
  input  logic [VREG_W-1:0]           cmd_vreg,
  input  logic [AW-1:0]               cmd_base,
  input  logic [AW:0]                 cmd_len,
  input  logic                        wr_data_vld,
  output logic                        wr_data_rdy,
  input  logic [VECTOR_REG_WIDTH-1:0] wr_data,
  output cntrl_req_t                  req,
  input  logic                        rsp_vld,
  input  logic [VREG_W-1:0]           rsp_addr,
  input  logic [VECTOR_REG_WIDTH-1:0] vreg_rd_data,
  output logic                        rd_data_vld,
  output logic [VECTOR_REG_WIDTH-1:0] rd_data,
  output logic                        done,
  output logic                        err,
  output logic                        starve
);

  localparam int RW = $clog2(STARVE_LIMIT + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(STARVE_LIMIT);

  vreq_state_e                 state_reg, state_next;
  logic                        write_reg;
  logic [VREG_W-1:0]           vreg_reg;
  logic [AW-1:0]               base_reg;
  logic [AW:0]                 len_reg;
  logic [AW:0]                 idx_reg;
  logic [VECTOR_REG_WIDTH-1:0] data_reg;
  logic [RW-1:0]               retry_reg;
  logic [RW-1:0]               retry_next;
  logic                        rd_data_vld_reg;
  logic [VECTOR_REG_WIDTH-1:0] rd_data_reg;
  logic                        err_reg;
  logic                        starve_reg;

  logic                        grant;
  logic                        last_elem;
  logic                        stray_rsp;
  logic [AW:0]                 remaining;

  // A response only counts as our grant when we are waiting for it and it
  // names our register; anything else is flagged and otherwise ignored.
  assign grant     = rsp_vld && (state_reg == WAIT) && (rsp_addr == vreg_reg);
  assign stray_rsp = rsp_vld && ((state_reg != WAIT) || (rsp_addr != vreg_reg));
  assign last_elem = ((idx_reg + (AW+1)'(1)) == len_reg);
  assign remaining = len_reg - idx_reg;
  assign retry_next = (retry_reg == RETRY_MAX) ? retry_reg : retry_reg + RW'(1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_vld) begin
          if (cmd_len == '0)  state_next = FIN;
          else if (cmd_write) state_next = LOAD;
          else                state_next = REQ;
        end
      end
      LOAD: if (wr_data_vld) state_next = REQ;
      REQ:  state_next = WAIT;
      WAIT: begin
        if (grant) begin
          if (last_elem)      state_next = FIN;
          else if (write_reg) state_next = LOAD;
          else                state_next = REQ;
        end else begin
          state_next = REQ;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      write_reg       <= 1'b0;
      vreg_reg        <= '0;
      base_reg        <= '0;
      len_reg         <= '0;
      idx_reg         <= '0;
      data_reg        <= '0;
      retry_reg       <= '0;
      rd_data_vld_reg <= 1'b0;
      rd_data_reg     <= '0;
      err_reg         <= 1'b0;
      starve_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rd_data_vld_reg <= 1'b0;

      if (state_reg == IDLE && cmd_vld) begin
        write_reg <= cmd_write;
        vreg_reg  <= cmd_vreg;
        base_reg  <= cmd_base;
        len_reg   <= cmd_len;
        idx_reg   <= '0;
        retry_reg <= '0;
      end

      if (state_reg == LOAD && wr_data_vld) data_reg <= wr_data;

      if (state_reg == WAIT) begin
        if (grant) begin
          idx_reg   <= idx_reg + (AW+1)'(1);
          retry_reg <= '0;
          if (!write_reg) begin
            rd_data_vld_reg <= 1'b1;
            rd_data_reg     <= vreg_rd_data;
          end
        end else begin
          // Saturating count of consecutive misses on the same element.
          retry_reg <= retry_next;
          if (retry_next == RETRY_MAX) starve_reg <= 1'b1;
        end
      end

      if (stray_rsp) err_reg <= 1'b1;
    end
  end

  always_comb begin
    req = '0;
    if (state_reg == REQ) begin
      req.vld           = 1'b1;
      req.vec_reg_ptr   = vreg_reg;
      req.addr          = elem_addr(base_reg, idx_reg);
      req.access_type   = write_reg ? WRITE_REQ : READ_REQ;
      req.access_length = remaining[AW-1:0];
      req.data          = write_reg ? data_reg : '0;
    end
  end

  assign cmd_rdy     = (state_reg == IDLE);
  assign wr_data_rdy = (state_reg == LOAD);
  assign done        = (state_reg == FIN);
  assign rd_data_vld = rd_data_vld_reg;
  assign rd_data     = rd_data_reg;
  assign err         = err_reg;
  assign starve      = starve_reg;

endmodule
